// File: rtl/aes_gf_pkg.sv
// rtl/aes_gf_pkg.sv - GF(2^8) helpers, mode constants and FSM type for the MixColumns engine
package aes_gf_pkg;

    localparam logic [7:0] POLY_DEFAULT = 8'h1b;
    localparam logic       MODE_FWD     = 1'b0;
    localparam logic       MODE_INV     = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mixcol_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
        return {x[6:0], 1'b0} ^ (poly & {8{x[7]}});
    endfunction

    // sel names the constant directly: 1, 2, 3, 9, b, d or e; anything else yields 0
    function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [3:0] sel,
                                                input logic [7:0] poly);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(x, poly);
        x4 = xtime(x2, poly);
        x8 = xtime(x4, poly);
        case (sel)
            4'h1:    r = x;
            4'h2:    r = x2;
            4'h3:    r = x2 ^ x;
            4'h9:    r = x8 ^ x;
            4'hb:    r = x8 ^ x2 ^ x;
            4'hd:    r = x8 ^ x4 ^ x;
            4'he:    r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// rtl/aes_mixcol_col.sv - combinational MixColumns/InvMixColumns transform of one 32-bit column
module aes_mixcol_col
    import aes_gf_pkg::*;
#(
    parameter logic [7:0] POLY = POLY_DEFAULT
) (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);

    logic [15:0] coefs;

    // Output byte i uses coefficient (j - i) mod 4 for input byte j
    always_comb begin
        coefs = (inv == MODE_INV) ? 16'hebd9 : 16'h2311;
        res   = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                res[31-8*i -: 8] = res[31-8*i -: 8]
                                 ^ gf_mul_const(col[31-8*j -: 8],
                                                coefs[15-4*((j-i+4)%4) -: 4], POLY);
            end
        end
    end

endmodule

// File: rtl/aes_mixcol_seq.sv
// rtl/aes_mixcol_seq.sv - sequential MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per cycle
module aes_mixcol_seq
    import aes_gf_pkg::*;
#(
    parameter int         COLS_PER_CYCLE = 1,
    parameter logic [7:0] POLY           = POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("aes_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mixcol_state_e fsm_q;
    mixcol_state_e fsm_d;
    logic [1:0]    col_cnt_q;
    logic [127:0]  st_q;
    logic [127:0]  st_upd;
    logic          mode_q;
    logic          last_step;

    logic [COLS_PER_CYCLE-1:0][31:0] col_src;
    logic [COLS_PER_CYCLE-1:0][31:0] col_res;

    assign last_step = (col_cnt_q == 2'(4 - COLS_PER_CYCLE));

    // Column select and write-back use constant slices so no index can fall outside the state
    always_comb begin
        col_src = '0;
        st_upd  = st_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (int'(col_cnt_q) + k == c) begin
                    col_src[k]             = st_q[127-32*c -: 32];
                    st_upd[127-32*c -: 32] = col_res[k];
                end
            end
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        aes_mixcol_col #(.POLY(POLY)) u_col (
            .col (col_src[k]),
            .inv (mode_q),
            .res (col_res[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid) fsm_d = RUN;
            RUN:     if (last_step) fsm_d = DONE;
            DONE:    if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q <= 2'd0;
            st_q      <= '0;
            mode_q    <= MODE_FWD;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q      <= in_state;
                        mode_q    <= in_inv;
                        col_cnt_q <= 2'd0;
                    end
                end
                RUN: begin
                    st_q      <= st_upd;
                    col_cnt_q <= col_cnt_q + 2'(COLS_PER_CYCLE);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        out_state = (fsm_q == DONE) ? st_q : '0;
    end

endmodule
